nixie_scan_driver: RTL

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It sits directly upstream of the hex-to-segment decoder. It holds a frame-coherent display value and cycles through the digits at a fixed rate. On each digit slot it presents one nibble on q_num for the decoder, drives a one-hot digit enable, and provides decimal-point and blank qualifiers. Dead time between digits suppresses ghosting, and leading zeros can optionally be blanked.

---
 rtl/nixie_pkg.sv | 25 ++
 rtl/scan_prescaler.sv | 16 +
 rtl/nixie_scan_driver.sv | 84 ++++++++
 3 files changed

// File: rtl/nixie_pkg.sv
// nixie_pkg: shared widths and digit enable / leading-zero helpers for the scan driver
package nixie_pkg;
    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 8;

    function automatic logic [MAX_DIGITS-1:0] dig_onehot(input int unsigned idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

    // Bit i set when nibbles MAX..i are all zero; digit 0 is never flagged
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [NIB_W*MAX_DIGITS-1:0] val,
                                                      input int digits);
        logic [MAX_DIGITS-1:0] m;
        logic z;
        m = '0;
        z = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < digits) begin
                z    = z & (val[NIB_W*i +: NIB_W] == '0);
                m[i] = z;
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running slot divider with terminal-count pulse
module scan_prescaler #(
    parameter int DIV = 50000,
    localparam int W  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = cnt == W'(DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/nixie_scan_driver.sv
// nixie_scan_driver: multiplexed digit scanner with frame-coherent commit and leading-zero blanking
module nixie_scan_driver
    import nixie_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [NIB_W*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]       dp_mask,
    input  logic                    blank_lz,
    output logic [NIB_W-1:0]        q_num,
    output logic [DIGITS-1:0]       dig_sel,
    output logic                    dp,
    output logic                    blank,
    output logic                    frame_start,
    output logic                    pending
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = NIB_W * DIGITS;

    logic [CW-1:0]         div_cnt;
    logic                  tc;
    logic [IW-1:0]         idx, idx_nx;
    logic [VW-1:0]         sh_val, act_val, val_nx;
    logic [DIGITS-1:0]     sh_dp, act_dp, dp_nx, blk_nx;
    logic [MAX_DIGITS-1:0] lz_all, oh_all;
    logic                  wrap, commit;

    scan_prescaler #(.DIV(SCAN_DIV)) u_pre (
        .clk(clk),
        .rst(rst),
        .cnt(div_cnt),
        .tc (tc)
    );

    // Next-slot values are computed from the post-commit data so outputs never lag a frame
    always_comb begin
        wrap    = idx == IW'(DIGITS - 1);
        commit  = tc && wrap && pending;
        idx_nx  = wrap ? '0 : idx + 1'b1;
        val_nx  = commit ? sh_val : act_val;
        dp_nx   = commit ? sh_dp : act_dp;
        lz_all  = lz_mask((NIB_W*MAX_DIGITS)'(val_nx), DIGITS);
        blk_nx  = blank_lz ? lz_all[DIGITS-1:0] : '0;
        oh_all  = dig_onehot(32'(idx));
        dig_sel = (int'(div_cnt) >= DEAD) ? oh_all[DIGITS-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx         <= '0;
            sh_val      <= '0;
            sh_dp       <= '0;
            act_val     <= '0;
            act_dp      <= '0;
            pending     <= 1'b0;
            q_num       <= '0;
            dp          <= 1'b0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tc && wrap;
            if (tc) begin
                idx   <= idx_nx;
                q_num <= val_nx[NIB_W*idx_nx +: NIB_W];
                dp    <= dp_nx[idx_nx];
                blank <= blk_nx[idx_nx];
            end
            if (commit) begin
                act_val <= sh_val;
                act_dp  <= sh_dp;
            end
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_mask;
            end
            pending <= load | (pending & ~commit);
        end
endmodule
